operand_fetch_stage: RTL and testbench

Pipeline stage between decode and execute in the CPU core. It takes a decoded instruction, reads source operands from the register file's combinational read ports, and resolves read-after-write hazards. Hazards are resolved by forwarding from the EX, MEM and WB stages, or by inserting a one-cycle bubble on a load-use dependency. It registers the resolved operands and control into the ID/EX pipeline register, with a valid/ready handshake on both sides and a flush input for branch redirects.

---
 rtl/operand_fetch_stage.sv | 197 +++++++++++++++++++
 tb/tb_operand_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode-to-execute pipeline stage.
// Reads source operands, resolves RAW hazards by forwarding from EX/MEM/WB,
// inserts a single bubble on a load-use dependency, and registers the
// resolved instruction into the ID/EX register behind a valid/ready handshake.
module operand_fetch_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  // decode side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rs1_addr,
  input  logic [4:0]       in_rs2_addr,
  input  logic             in_use_rs1,
  input  logic             in_use_rs2,
  input  logic [4:0]       in_rd_addr,
  input  logic             in_rd_we,
  input  logic             in_is_load,
  // register file read data
  input  logic [XLEN-1:0]  rf_rs1_data,
  input  logic [XLEN-1:0]  rf_rs2_data,
  // forwarding sources
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_we,
  input  logic             ex_is_load,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [4:0]       mem_rd_addr,
  input  logic             mem_rd_we,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_rd_we,
  input  logic [XLEN-1:0]  wb_data,
  // redirect
  input  logic             flush,
  // execute side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [4:0]       out_rd_addr,
  output logic             out_rd_we,
  output logic             out_is_load,
  output logic [CNT_W-1:0] stall_count
);

  // Forwarding priority: x0, then youngest producer (EX, non-load), MEM, WB,
  // finally the register file. WB bypass covers same-cycle write/read.
  function automatic logic [XLEN-1:0] resolve_operand(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_data,
    input logic [4:0]      ex_addr,
    input logic            ex_we,
    input logic            ex_load,
    input logic [XLEN-1:0] ex_val,
    input logic [4:0]      mem_addr,
    input logic            mem_we,
    input logic [XLEN-1:0] mem_val,
    input logic [4:0]      wb_addr,
    input logic            wb_we,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] result;
    if (addr == 5'd0) begin
      result = {XLEN{1'b0}};
    end else if (ex_we && (ex_addr == addr) && !ex_load) begin
      result = ex_val;
    end else if (mem_we && (mem_addr == addr)) begin
      result = mem_val;
    end else if (wb_we && (wb_addr == addr)) begin
      result = wb_val;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0]  op1_s;
  logic [XLEN-1:0]  op2_s;
  logic             rs1_ex_hit_s;
  logic             rs2_ex_hit_s;
  logic             hazard_s;
  logic             hold_s;

  logic             valid_r;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  imm_r;
  logic [XLEN-1:0]  op1_r;
  logic [XLEN-1:0]  op2_r;
  logic [4:0]       rd_addr_r;
  logic             rd_we_r;
  logic             is_load_r;
  logic [CNT_W-1:0] stall_r;

  // Resolve both source operands through the forwarding network.
  always_comb begin
    op1_s = resolve_operand(in_rs1_addr, rf_rs1_data,
                            ex_rd_addr, ex_rd_we, ex_is_load, ex_result,
                            mem_rd_addr, mem_rd_we, mem_result,
                            wb_rd_addr, wb_rd_we, wb_data);
    op2_s = resolve_operand(in_rs2_addr, rf_rs2_data,
                            ex_rd_addr, ex_rd_we, ex_is_load, ex_result,
                            mem_rd_addr, mem_rd_we, mem_result,
                            wb_rd_addr, wb_rd_we, wb_data);
  end

  // Detect a load in EX whose result the decode instruction needs now.
  always_comb begin
    rs1_ex_hit_s = in_use_rs1 && (in_rs1_addr == ex_rd_addr);
    rs2_ex_hit_s = in_use_rs2 && (in_rs2_addr == ex_rd_addr);
    hazard_s     = in_valid && ex_rd_we && ex_is_load &&
                   (ex_rd_addr != 5'd0) && (rs1_ex_hit_s || rs2_ex_hit_s);
    hold_s       = valid_r && !out_ready;
  end

  // Decode handshake: flush always drains decode, hold and hazard block it.
  always_comb begin
    in_ready = 1'b1;
    if (flush) begin
      in_ready = 1'b1;
    end else if (hold_s) begin
      in_ready = 1'b0;
    end else if (hazard_s) begin
      in_ready = 1'b0;
    end else begin
      in_ready = 1'b1;
    end
  end

  // ID/EX register: flush > hold > bubble > accept. Data fields only load on
  // accept so they stay stable while the register is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r   <= 1'b0;
      pc_r      <= {XLEN{1'b0}};
      imm_r     <= {XLEN{1'b0}};
      op1_r     <= {XLEN{1'b0}};
      op2_r     <= {XLEN{1'b0}};
      rd_addr_r <= 5'd0;
      rd_we_r   <= 1'b0;
      is_load_r <= 1'b0;
    end else if (flush) begin
      valid_r   <= 1'b0;
      rd_we_r   <= 1'b0;
    end else if (hold_s) begin
      valid_r   <= valid_r;
    end else if (hazard_s) begin
      valid_r   <= 1'b0;
      rd_we_r   <= 1'b0;
    end else if (in_valid) begin
      valid_r   <= 1'b1;
      pc_r      <= in_pc;
      imm_r     <= in_imm;
      op1_r     <= op1_s;
      op2_r     <= op2_s;
      rd_addr_r <= in_rd_addr;
      rd_we_r   <= in_rd_we;
      is_load_r <= in_is_load;
    end else begin
      valid_r   <= 1'b0;
      rd_we_r   <= 1'b0;
    end
  end

  // Count inserted load-use bubbles, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_r <= {CNT_W{1'b0}};
    end else if (!flush && !hold_s && hazard_s && (stall_r != CNT_MAX)) begin
      stall_r <= stall_r + CNT_ONE;
    end else begin
      stall_r <= stall_r;
    end
  end

  // Drive outputs straight from registers.
  always_comb begin
    out_valid   = valid_r;
    out_pc      = pc_r;
    out_imm     = imm_r;
    out_op1     = op1_r;
    out_op2     = op2_r;
    out_rd_addr = rd_addr_r;
    out_rd_we   = rd_we_r;
    out_is_load = is_load_r;
    stall_count = stall_r;
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed testbench for operand_fetch_stage with hand-computed expectations.
module tb_operand_fetch_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [XLEN-1:0]  in_pc, in_imm;
  logic [4:0]       in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic             in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
  logic [XLEN-1:0]  rf_rs1_data, rf_rs2_data;
  logic [4:0]       ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic             ex_rd_we, ex_is_load, mem_rd_we, wb_rd_we;
  logic [XLEN-1:0]  ex_result, mem_result, wb_data;
  logic             flush;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_pc, out_imm, out_op1, out_op2;
  logic [4:0]       out_rd_addr;
  logic             out_rd_we, out_is_load;
  logic [CNT_W-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  operand_fetch_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_rd_addr(mem_rd_addr), .mem_rd_we(mem_rd_we), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_op1(out_op1), .out_op2(out_op2),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_is_load(out_is_load),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_pc = 32'd0; in_imm = 32'd0;
    in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; in_rd_addr = 5'd0;
    in_use_rs1 = 1'b0; in_use_rs2 = 1'b0; in_rd_we = 1'b0; in_is_load = 1'b0;
    rf_rs1_data = 32'd0; rf_rs2_data = 32'd0;
    ex_rd_addr = 5'd0; ex_rd_we = 1'b0; ex_is_load = 1'b0; ex_result = 32'd0;
    mem_rd_addr = 5'd0; mem_rd_we = 1'b0; mem_result = 32'd0;
    wb_rd_addr = 5'd0; wb_rd_we = 1'b0; wb_data = 32'd0;
    flush = 1'b0; out_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_op1", out_op1, 32'd0);
    chk("rst_stall", {29'd0, stall_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    tick();

    // rs1=x3 from rf, rs2=x0 forced to zero
    in_valid = 1'b1; in_pc = 32'h100; in_imm = 32'h4; in_rd_addr = 5'd1; in_rd_we = 1'b1;
    in_rs1_addr = 5'd3; in_rs2_addr = 5'd0; in_use_rs1 = 1'b1; in_use_rs2 = 1'b1;
    rf_rs1_data = 32'h11; rf_rs2_data = 32'hDEAD;
    #1 chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_op1", out_op1, 32'h11);
    chk("t1_op2", out_op2, 32'd0);
    chk("t1_pc", out_pc, 32'h100);
    chk("t1_imm", out_imm, 32'h4);
    chk("t1_rd", {27'd0, out_rd_addr}, 32'd1);
    chk("t1_rd_we", {31'd0, out_rd_we}, 32'd1);

    // Forwarding priority EX > MEM > WB
    in_rs1_addr = 5'd5; in_pc = 32'h104; rf_rs1_data = 32'h55;
    ex_rd_addr = 5'd5; ex_rd_we = 1'b1; ex_result = 32'hA;
    mem_rd_addr = 5'd5; mem_rd_we = 1'b1; mem_result = 32'hB;
    wb_rd_addr = 5'd5; wb_rd_we = 1'b1; wb_data = 32'hC;
    tick();
    chk("fwd_ex", out_op1, 32'hA);
    ex_rd_we = 1'b0;
    tick();
    chk("fwd_mem", out_op1, 32'hB);
    mem_rd_we = 1'b0;
    tick();
    chk("fwd_wb", out_op1, 32'hC);
    wb_rd_we = 1'b0;
    tick();
    chk("fwd_rf", out_op1, 32'h55);

    // Load in EX to x7 but rs2 not used: no bubble, rf value passes
    in_rs1_addr = 5'd0; in_rs2_addr = 5'd7; in_use_rs2 = 1'b0; rf_rs2_data = 32'h77;
    in_pc = 32'h108; in_is_load = 1'b0;
    ex_rd_addr = 5'd7; ex_rd_we = 1'b1; ex_is_load = 1'b1; ex_result = 32'hBAD;
    #1 chk("nohaz_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("nohaz_valid", {31'd0, out_valid}, 32'd1);
    chk("nohaz_op2", out_op2, 32'h77);
    chk("nohaz_stall", {29'd0, stall_count}, 32'd0);

    // Load-use on rs2: one bubble, then forward from MEM
    in_use_rs2 = 1'b1; in_pc = 32'h10C;
    #1 chk("haz_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("haz_valid", {31'd0, out_valid}, 32'd0);
    chk("haz_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("haz_stall", {29'd0, stall_count}, 32'd1);
    chk("haz_pc_stable", out_pc, 32'h108);
    ex_rd_we = 1'b0; ex_is_load = 1'b0;
    mem_rd_addr = 5'd7; mem_rd_we = 1'b1; mem_result = 32'h42;
    #1 chk("haz2_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("haz2_valid", {31'd0, out_valid}, 32'd1);
    chk("haz2_op2", out_op2, 32'h42);
    chk("haz2_pc", out_pc, 32'h10C);
    mem_rd_we = 1'b0;

    // Hold with a concurrent hazard: hold wins, no count
    out_ready = 1'b0; in_pc = 32'h200;
    ex_rd_addr = 5'd7; ex_rd_we = 1'b1; ex_is_load = 1'b1;
    #1 chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_pc", out_pc, 32'h10C);
    chk("hold_op2", out_op2, 32'h42);
    chk("hold_stall", {29'd0, stall_count}, 32'd1);
    #1 chk("hold2_in_ready", {31'd0, in_ready}, 32'd0);
    // Flush while holding
    flush = 1'b1;
    #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("flush_stall", {29'd0, stall_count}, 32'd1);
    flush = 1'b0; out_ready = 1'b1;

    // Drive hazards until the 3-bit counter saturates
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    chk("sat_stall", {29'd0, stall_count}, 32'd7);
    tick();
    chk("sat_hold", {29'd0, stall_count}, 32'd7);
    chk("sat_pc_stable", out_pc, 32'h10C);

    // Asynchronous reset mid-bubble
    #3 rst = 1'b1;
    #1;
    chk("arst_stall", {29'd0, stall_count}, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_op2", out_op2, 32'd0);
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_imm", out_imm, 32'd0);
    @(negedge clk); rst = 1'b0;
    ex_rd_we = 1'b0; ex_is_load = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
